// File: rtl/vector_mem_pkg.sv
// Shared widths, FSM state and response-tracking entry
// for the vector memory arbiter.
package vector_mem_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 64;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_MAX_OUT = 8;
    localparam int ID_W        = $clog2(DEF_NUM_REQ);

    typedef enum logic {
        IDLE     = 1'b0,
        WR_BURST = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [ID_W-1:0]      id;
        logic [DEF_LEN_W-1:0] len;
    } rsp_ent_t;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1) % n;
    endfunction

endpackage

// File: rtl/vector_sync_fifo.sv
// Single-clock FIFO tracking outstanding read commands;
// a push and a pop in one cycle both take effect.
module vector_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/vector_mem_arbiter.sv
// Round-robin arbiter of vector load/store ports onto one
// memory port, with locked write bursts and read routing.
module vector_mem_arbiter
    import vector_mem_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int MAX_OUT = DEF_MAX_OUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_we,
    output logic [ADDR_W-1:0]         mem_req_addr,
    output logic [LEN_W-1:0]          mem_req_len,
    output logic [DATA_W-1:0]         mem_req_wdata,
    output logic                      mem_req_last,
    input  logic                      mem_rsp_valid,
    input  logic [DATA_W-1:0]         mem_rsp_rdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata
);

    localparam int IDW = $clog2(NUM_REQ);

    arb_state_t     state;
    arb_state_t     state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] rr_pick;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] gnt;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] rsp_cnt;
    logic           lock;
    logic           rr_found;
    logic           gnt_vld;
    logic           xfer;
    logic           rd_ok;
    logic           push;
    logic           pop;
    logic           rsp_fire;
    logic           fifo_full;
    logic           fifo_empty;
    rsp_ent_t       push_ent;
    rsp_ent_t       head;

    vector_sync_fifo #(
        .WIDTH ($bits(rsp_ent_t)),
        .DEPTH (MAX_OUT)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_ent),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A read may enter a full tracker only if a slot frees this cycle.
    assign rsp_fire = mem_rsp_valid && !fifo_empty;
    assign pop      = rsp_fire && (rsp_cnt == head.len);
    assign rd_ok    = !fifo_full || pop;
    assign push     = xfer && (state == IDLE) && !mem_req_we;
    assign push_ent = '{id: gnt, len: mem_req_len};

    // Round-robin search starting at rr_ptr over eligible requesters.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!rr_found
                && req_valid[(int'(rr_ptr) + k) % NUM_REQ]
                && (req_we[(int'(rr_ptr) + k) % NUM_REQ] || rd_ok)) begin
                rr_found = 1'b1;
                rr_pick  = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Grant: locked during bursts and stalled beats, else round-robin.
    always_comb begin
        gnt     = rr_pick;
        gnt_vld = rr_found;
        if (state == WR_BURST || lock) begin
            gnt     = gnt_id;
            gnt_vld = 1'b1;
        end
        gnt_vld = gnt_vld && reset;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (xfer && mem_req_we && mem_req_len != '0)
                    state_nxt = WR_BURST;
            end
            WR_BURST: begin
                if (xfer && beat_cnt == LEN_W'(1))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: mux the granted requester onto the memory port.
    always_comb begin
        req_ready     = '0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_len   = '0;
        mem_req_wdata = '0;
        mem_req_last  = 1'b0;
        if (gnt_vld) begin
            req_ready[gnt] = mem_req_ready;
            mem_req_valid  = req_valid[gnt];
            mem_req_we     = req_we[gnt];
            mem_req_addr   = req_addr[gnt*ADDR_W +: ADDR_W];
            mem_req_len    = req_len[gnt*LEN_W +: LEN_W];
            mem_req_wdata  = req_wdata[gnt*DATA_W +: DATA_W];
            if (state == WR_BURST)
                mem_req_last = (beat_cnt == LEN_W'(1));
            else
                mem_req_last = !req_we[gnt]
                               || (req_len[gnt*LEN_W +: LEN_W] == '0);
        end
        xfer = mem_req_valid && mem_req_ready;
    end

    // Arbitration bookkeeping: pointer, burst count, grant lock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= '0;
            beat_cnt <= '0;
            gnt_id   <= '0;
            lock     <= 1'b0;
        end else begin
            lock <= (state == IDLE) && mem_req_valid && !mem_req_ready;
            if (state == IDLE) gnt_id <= gnt;
            if (xfer) begin
                if (state == WR_BURST) begin
                    beat_cnt <= beat_cnt - 1'b1;
                    if (beat_cnt == LEN_W'(1))
                        rr_ptr <= IDW'(wrap_inc(int'(gnt), NUM_REQ));
                end else if (mem_req_we && mem_req_len != '0) begin
                    beat_cnt <= mem_req_len;
                end else begin
                    rr_ptr <= IDW'(wrap_inc(int'(gnt), NUM_REQ));
                end
            end
        end
    end

    // Count response beats received for the head read command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        rsp_cnt <= '0;
        else if (pop)      rsp_cnt <= '0;
        else if (rsp_fire) rsp_cnt <= rsp_cnt + 1'b1;
    end

    // Route each response beat to the owner of the head entry.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (rsp_fire) begin
            rsp_valid[head.id] = 1'b1;
            rsp_rdata          = mem_rsp_rdata;
        end
    end

endmodule

// File: tb/tb_vector_mem_arbiter.sv
// Directed bench for vector_mem_arbiter: arbitration, bursts,
// stalls, read tracking and reset.
module tb_vector_mem_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int LW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*LW-1:0] req_len;
    logic [NR*DW-1:0] req_wdata;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic             mem_req_we;
    logic [AW-1:0]    mem_req_addr;
    logic [LW-1:0]    mem_req_len;
    logic [DW-1:0]    mem_req_wdata;
    logic             mem_req_last;
    logic             mem_rsp_valid;
    logic [DW-1:0]    mem_rsp_rdata;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;

    int checks = 0;
    int errors = 0;

    vector_mem_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .req_wdata     (req_wdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_len   (mem_req_len),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_last  (mem_req_last),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic v, input logic we,
                       input logic [AW-1:0] a, input logic [LW-1:0] l,
                       input logic [DW-1:0] d);
        req_valid[i]           = v;
        req_we[i]              = we;
        req_addr[i*AW +: AW]   = a;
        req_len[i*LW +: LW]    = l;
        req_wdata[i*DW +: DW]  = d;
    endtask

    task automatic setw(input int i, input logic [DW-1:0] d);
        req_wdata[i*DW +: DW] = d;
    endtask

    initial begin
        reset         = 1'b0;
        req_valid     = '0;
        req_we        = '0;
        req_addr      = '0;
        req_len       = '0;
        req_wdata     = '0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;

        // reset: outputs forced low even with live inputs
        put(0, 1'b1, 1'b0, 32'h10, 4'd0, 64'h5);
        put(1, 1'b1, 1'b1, 32'h20, 4'd0, 64'h6);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hDEAD;
        repeat (2) tick();
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_mvalid", 64'(mem_req_valid), 64'h0);
        chk("rst_addr", 64'(mem_req_addr), 64'h0);
        chk("rst_wdata", mem_req_wdata, 64'h0);
        chk("rst_last", 64'(mem_req_last), 64'h0);
        chk("rst_rsp", 64'(rsp_valid), 64'h0);
        chk("rst_rdata", rsp_rdata, 64'h0);
        req_valid     = '0;
        mem_rsp_valid = 1'b0;
        #2 reset = 1'b1;
        tick();

        // two simultaneous reads, rr_ptr=0
        put(0, 1'b1, 1'b0, 32'h100, 4'd0, 64'h0);
        put(2, 1'b1, 1'b0, 32'h200, 4'd0, 64'h0);
        #1;
        chk("rr_first", 64'(req_ready), 64'h1);
        chk("rr_addr0", 64'(mem_req_addr), 64'h100);
        chk("rd_last", 64'(mem_req_last), 64'h1);
        tick();
        req_valid[0] = 1'b0;
        #1;
        chk("rr_second", 64'(req_ready), 64'h4);
        chk("rr_addr2", 64'(mem_req_addr), 64'h200);
        tick();
        req_valid[2]  = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hAAAA;
        #1;
        chk("idle_novalid", 64'(mem_req_valid), 64'h0);
        chk("rsp_to0", 64'(rsp_valid), 64'h1);
        chk("rsp_data", rsp_rdata, 64'hAAAA);
        tick();
        mem_rsp_rdata = 64'hBBBB;
        #1;
        chk("rsp_to2", 64'(rsp_valid), 64'h4);
        tick();
        mem_rsp_valid = 1'b0;

        // single-beat write from 3 moves rr_ptr to 0
        put(3, 1'b1, 1'b1, 32'h3F0, 4'd0, 64'h33);
        #1;
        chk("w1_ready", 64'(req_ready), 64'h8);
        chk("w1_we", 64'(mem_req_we), 64'h1);
        chk("w1_last", 64'(mem_req_last), 64'h1);
        tick();

        // 4-beat write from 1 while 3 also waits
        put(1, 1'b1, 1'b1, 32'h300, 4'd3, 64'h11);
        put(3, 1'b1, 1'b1, 32'h400, 4'd0, 64'h33);
        #1;
        chk("wb1_ready", 64'(req_ready), 64'h2);
        chk("wb1_len", 64'(mem_req_len), 64'h3);
        chk("wb1_last", 64'(mem_req_last), 64'h0);
        tick();
        setw(1, 64'h12);
        #1;
        chk("wb2_ready", 64'(req_ready), 64'h2);
        chk("wb2_wdata", mem_req_wdata, 64'h12);
        chk("wb2_last", 64'(mem_req_last), 64'h0);
        tick();
        setw(1, 64'h13);
        #1;
        chk("wb3_last", 64'(mem_req_last), 64'h0);
        tick();
        setw(1, 64'h14);
        #1;
        chk("wb4_ready", 64'(req_ready), 64'h2);
        chk("wb4_last", 64'(mem_req_last), 64'h1);
        tick();
        req_valid[1] = 1'b0;
        #1;
        chk("after_burst", 64'(req_ready), 64'h8);
        chk("after_wdata", mem_req_wdata, 64'h33);
        tick();
        req_valid[3] = 1'b0;

        // 2-beat write from 0, memory stalls on beat 2
        put(0, 1'b1, 1'b1, 32'h500, 4'd1, 64'hB1);
        put(2, 1'b1, 1'b0, 32'h600, 4'd0, 64'h0);
        #1;
        chk("st_beat1", 64'(req_ready), 64'h1);
        tick();
        setw(0, 64'hB2);
        mem_req_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("st_ready", 64'(req_ready), 64'h0);
            chk("st_wdata", mem_req_wdata, 64'hB2);
            chk("st_last", 64'(mem_req_last), 64'h1);
            tick();
        end
        mem_req_ready = 1'b1;
        #1;
        chk("st_resume", 64'(req_ready), 64'h1);
        chk("st_rlast", 64'(mem_req_last), 64'h1);
        tick();
        req_valid[0] = 1'b0;
        #1;
        chk("st_next", 64'(req_ready), 64'h4);
        tick();
        req_valid[2]  = 1'b0;
        mem_rsp_valid = 1'b1;
        #1;
        chk("st_rsp", 64'(rsp_valid), 64'h4);
        tick();
        mem_rsp_valid = 1'b0;

        // 3-beat read from 3
        put(3, 1'b1, 1'b0, 32'h700, 4'd2, 64'h0);
        #1;
        chk("rl_ready", 64'(req_ready), 64'h8);
        chk("rl_len", 64'(mem_req_len), 64'h2);
        tick();
        req_valid[3]  = 1'b0;
        mem_rsp_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            #1;
            chk("rl_rsp", 64'(rsp_valid), 64'h8);
            tick();
        end
        #1;
        chk("rl_popped", 64'(rsp_valid), 64'h0);
        mem_rsp_valid = 1'b0;

        // fill the tracker with 8 reads
        put(0, 1'b1, 1'b0, 32'h800, 4'd0, 64'h0);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("fill_ready", 64'(req_ready), 64'h1);
            tick();
        end
        #1;
        chk("full_ready", 64'(req_ready), 64'h0);
        chk("full_mvalid", 64'(mem_req_valid), 64'h0);
        mem_rsp_valid = 1'b1;
        #1;
        chk("pop_ready", 64'(req_ready), 64'h1);
        chk("pop_rsp", 64'(rsp_valid), 64'h1);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("still_full", 64'(req_ready), 64'h0);
        req_valid[0]  = 1'b0;
        mem_rsp_valid = 1'b1;
        repeat (6) tick();
        mem_rsp_valid = 1'b0;

        // reset mid-burst with 2 reads outstanding
        put(2, 1'b1, 1'b1, 32'h900, 4'd3, 64'hC1);
        #1;
        chk("mr_beat1", 64'(req_ready), 64'h4);
        tick();
        setw(2, 64'hC2);
        #1;
        chk("mr_locked", 64'(req_ready), 64'h4);
        reset         = 1'b0;
        mem_rsp_valid = 1'b1;
        put(1, 1'b1, 1'b0, 32'hA00, 4'd0, 64'h0);
        #1;
        chk("mr_ready", 64'(req_ready), 64'h0);
        chk("mr_mvalid", 64'(mem_req_valid), 64'h0);
        chk("mr_rsp", 64'(rsp_valid), 64'h0);
        chk("mr_wdata", mem_req_wdata, 64'h0);
        chk("mr_last", 64'(mem_req_last), 64'h0);
        reset = 1'b1;
        #1;
        chk("post_grant", 64'(req_ready), 64'h2);
        chk("post_last", 64'(mem_req_last), 64'h1);
        chk("post_rsp", 64'(rsp_valid), 64'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_mem_arbiter.md
VECTOR_MEM_ARBITER -- requirements
Module: vector_mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters (vector load/store lanes/ports).
REQ-002 Parameter ADDR_W, 32, address width.
REQ-003 Parameter DATA_W, 64, data width.
REQ-004 Parameter LEN_W, 4, burst length field width (beats minus one).
REQ-005 Parameter MAX_OUT, 8, maximum outstanding read commands; power of two.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 req_valid  input  NUM_REQ  per-requester command/beat valid.
REQ-009 req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-010 req_we  input  NUM_REQ  1 = write, 0 = read.
REQ-011 req_addr  input  NUM_REQ*ADDR_W  per-requester address.
REQ-012 req_len  input  NUM_REQ*LEN_W  beats minus one.
REQ-013 req_wdata  input  NUM_REQ*DATA_W  per-requester write data.
REQ-014 mem_req_valid / mem_req_ready  output/input  1 each  memory command/beat handshake.
REQ-015 mem_req_we, mem_req_addr, mem_req_len, mem_req_wdata  output  1/ADDR_W/LEN_W/DATA_W  muxed fields of the granted requester.
REQ-016 mem_req_last  output  1  final write beat, or any read command.
REQ-017 mem_rsp_valid, mem_rsp_rdata  input  1/DATA_W  in-order read data from memory; always accepted.
REQ-018 rsp_valid  output  NUM_REQ  one-hot routed read response; rsp_rdata  output  DATA_W  broadcast data.

Function
REQ-019 Transfer occurs when mem_req_valid and mem_req_ready are both high; req_ready[i] SHALL equal mem_req_ready gated by grant to i.
REQ-020 The FSM SHALL have states IDLE and WR_BURST.
REQ-021 IDLE: grant SHALL go to the first valid requester after rr_ptr (round-robin). Reads SHALL be blocked when the response FIFO is full.
REQ-022 IDLE read transfer: one beat, mem_req_last=1; push {grantee, len} to the response FIFO; rr_ptr <= grantee+1 (mod NUM_REQ); stay in IDLE.
REQ-023 IDLE write transfer with len=0: mem_req_last=1; rr_ptr advances; stay in IDLE.
REQ-024 IDLE write transfer with len>0: latch grantee and beat_cnt=len; go to WR_BURST.
REQ-025 WR_BURST: grant SHALL be locked to the latched requester and other requests ignored. Each transfer decrements beat_cnt. mem_req_last=1 when beat_cnt==1. On the last transfer, advance rr_ptr past the grantee and return to IDLE.
REQ-026 mem_req_valid SHALL be combinational from the granted req_valid, with no added latency. Address, len and we are meaningful only on the first beat.
REQ-027 Response routing: each mem_rsp_valid beat SHALL assert rsp_valid[head.id] in the same cycle and decrement the head beat counter. The FIFO pops on the beat where the count reaches zero.
REQ-028 A push and a pop in the same cycle SHALL both take effect, and the occupancy is unchanged.
REQ-029 mem_rsp_valid with an empty FIFO is illegal; the block SHALL drop the data and keep rsp_valid=0.
REQ-030 Requesters SHALL hold valid and fields stable until ready; the arbiter SHALL not change the grant while the granted valid is high and the beat is not accepted.

Reset
REQ-031 When reset is low: state=IDLE, rr_ptr=0, beat_cnt=0, FIFO empty, and all outputs 0 (req_ready, mem_req_valid, rsp_valid, data fields).
REQ-032 Reset mid-burst SHALL abandon the burst and clear all outstanding read tracking, with no residual rsp_valid.

Structure
REQ-033 A shared package vector_mem_pkg SHALL hold default widths, the FSM state enum and the FIFO entry struct {id, len}.
REQ-034 The response FIFO SHALL be a sub-module vector_sync_fifo (depth MAX_OUT, same clk/reset) with full/empty flags and simultaneous push/pop.

Verification
REQ-035 Requesters 0 and 2 each issue a read at the same time, mem_req_ready=1, rr_ptr=0 -> 0 is granted in cycle 0 and 2 in cycle 1; responses in order route rsp_valid=0001 then 0100.
REQ-036 Requester 1 writes len=3 while requester 3 is also valid -> 4 beats from requester 1 with mem_req_last on beat 4 only; requester 3 is granted in the next cycle.
REQ-037 Issue 8 single-beat reads with no responses -> 9th read is stalled (req_ready=0); one response arrives -> the stalled read is accepted in the same cycle as the pop.
REQ-038 Read with len=2 from requester 3 -> three mem_rsp_valid beats all route to rsp_valid=1000, and the FIFO pops after the third.
REQ-039 mem_req_ready held low for 5 cycles during the WR_BURST second beat -> grant, wdata and beat_cnt hold; the burst completes after ready rises.
REQ-040 Assert reset in the middle of a write burst with 2 reads outstanding -> all outputs are 0, state=IDLE, FIFO empty; the first request after reset is granted from rr_ptr=0.
